// File: rtl/test_result_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | test_result_monitor: latches the pass/fail/timeout verdict of a          |
// | riscv-tests program. Optional timeout: `TEST_MONITOR_TIMEOUT_EN.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module test_result_monitor #(
    parameter logic [31:0] DONE_PC     = 32'h0000_0044,
    parameter int          HOLD_CYCLES = 2,
    parameter logic [31:0] TIMEOUT     = 32'd6000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    input  logic [31:0] gp,
    output logic        done,
    output logic        passed,
    output logic        timed_out,
    output logic [30:0] fail_num,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_HOLD = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TMO  = 3'd4
    } state_t;

    localparam logic [3:0]  C_HOLD     = 4'(HOLD_CYCLES);
    localparam logic [31:0] C_TMO_LAST = TIMEOUT - 32'd1;

    state_t      state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [31:0] cycle_q, cycle_d;
    logic        done_q, done_d;
    logic        passed_q, passed_d;
    logic        tmo_q, tmo_d;
    logic [30:0] fnum_q, fnum_d;

    logic        w_qual;
    logic        w_verdict;
    logic        w_tmo_hit;
    logic [3:0]  w_hold_inc;

    assign w_qual     = pc_valid && (pc == DONE_PC);
    assign w_hold_inc = hold_q + 4'd1;

`ifdef TEST_MONITOR_TIMEOUT_EN
    assign w_tmo_hit = (cycle_q == C_TMO_LAST);
`else
    logic w_tmo_unused;
    assign w_tmo_unused = (cycle_q == C_TMO_LAST);
    assign w_tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        done_d    = done_q;
        passed_d  = passed_q;
        tmo_d     = tmo_q;
        fnum_d    = fnum_q;
        w_verdict = 1'b0;

        case (state_q)
            S_RUN: begin
                if (w_qual) begin
                    hold_d = 4'd1;
                    if (HOLD_CYCLES == 1) begin
                        w_verdict = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_qual) begin
                    hold_d = w_hold_inc;
                    if (w_hold_inc == C_HOLD) begin
                        w_verdict = 1'b1;
                    end
                end else begin
                    // A dwell broken by a flush or bubble starts over.
                    hold_d  = 4'd0;
                    state_d = S_RUN;
                end
            end
            default: ;
        endcase

        // Completion takes priority over a coincident timeout.
        if (w_verdict) begin
            done_d = 1'b1;
            if (gp == 32'h0000_0001) begin
                state_d  = S_PASS;
                passed_d = 1'b1;
                fnum_d   = 31'd0;
            end else begin
                state_d  = S_FAIL;
                passed_d = 1'b0;
                fnum_d   = gp[31:1];
            end
        end else if ((state_q == S_RUN || state_q == S_HOLD) && w_tmo_hit) begin
            state_d = S_TMO;
            done_d  = 1'b1;
            tmo_d   = 1'b1;
        end

        // The counter freezes on the edge that enters a terminal state.
        if ((state_d == S_RUN || state_d == S_HOLD) && (cycle_q != 32'hFFFF_FFFF)) begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            hold_q   <= 4'd0;
            cycle_q  <= 32'd0;
            done_q   <= 1'b0;
            passed_q <= 1'b0;
            tmo_q    <= 1'b0;
            fnum_q   <= 31'd0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            cycle_q  <= cycle_d;
            done_q   <= done_d;
            passed_q <= passed_d;
            tmo_q    <= tmo_d;
            fnum_q   <= fnum_d;
        end
    end

    assign done        = done_q;
    assign passed      = passed_q;
    assign timed_out   = tmo_q;
    assign fail_num    = fnum_q;
    assign cycle_count = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_test_result_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_test_result_monitor: vector table and scoreboard bench for the        |
// | verdict monitor (long-budget unit A, TIMEOUT=50 unit B).                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_test_result_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_a, gp_a, pc_b, gp_b;
    logic        v_a, v_b;

    logic        done_a, passed_a, tmo_a;
    logic [30:0] fnum_a;
    logic [31:0] cc_a;
    logic        done_b, passed_b, tmo_b;
    logic [30:0] fnum_b;
    logic [31:0] cc_b;

    always #5 clk = ~clk;

    test_result_monitor #(
        .DONE_PC    (32'h0000_0044),
        .HOLD_CYCLES(2),
        .TIMEOUT    (32'd6000)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc_a),
        .pc_valid   (v_a),
        .gp         (gp_a),
        .done       (done_a),
        .passed     (passed_a),
        .timed_out  (tmo_a),
        .fail_num   (fnum_a),
        .cycle_count(cc_a)
    );

    test_result_monitor #(
        .DONE_PC    (32'h0000_0044),
        .HOLD_CYCLES(2),
        .TIMEOUT    (32'd50)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc_b),
        .pc_valid   (v_b),
        .gp         (gp_b),
        .done       (done_b),
        .passed     (passed_b),
        .timed_out  (tmo_b),
        .fail_num   (fnum_b),
        .cycle_count(cc_b)
    );

    typedef struct {
        logic        sel;
        logic        rst;
        logic [31:0] pc;
        logic        v;
        logic [31:0] gp;
        logic        chk;
        logic        done;
        logic        passed;
        logic        tmo;
        logic [30:0] fnum;
        logic [31:0] cc;
    } vec_t;

    vec_t tbl[23];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input logic sel, input logic r, input logic [31:0] p,
                                input logic v, input logic [31:0] g, input logic chk,
                                input logic d, input logic ps, input logic t,
                                input logic [30:0] f, input logic [31:0] c);
        vec_t x;
        x.sel = sel; x.rst = r; x.pc = p; x.v = v; x.gp = g; x.chk = chk;
        x.done = d; x.passed = ps; x.tmo = t; x.fnum = f; x.cc = c;
        return x;
    endfunction

    // Drives unit A's inputs from the record (unit B's are set by the caller).
    task automatic apply(input vec_t x, input string tag, input int id);
        vec_t        e;
        logic        ad, ap, at;
        logic [30:0] af;
        logic [31:0] ac;
        rst  = x.rst;
        pc_a = x.pc;
        v_a  = x.v;
        gp_a = x.gp;
        if (x.chk) exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (x.chk) begin
            e = exp_q.pop_front();
            if (e.sel) begin
                ad = done_b; ap = passed_b; at = tmo_b; af = fnum_b; ac = cc_b;
            end else begin
                ad = done_a; ap = passed_a; at = tmo_a; af = fnum_a; ac = cc_a;
            end
            n_checks++;
            if (ad === e.done && ap === e.passed && at === e.tmo &&
                af === e.fnum && ac === e.cc) begin
                n_pass++;
            end else begin
                $display("FAIL %s[%0d] unit%0d: got done=%0b passed=%0b tmo=%0b fail_num=%0h cc=%0d, want done=%0b passed=%0b tmo=%0b fail_num=%0h cc=%0d",
                         tag, id, e.sel, ad, ap, at, af, ac,
                         e.done, e.passed, e.tmo, e.fnum, e.cc);
            end
        end
    endtask

    initial begin
        logic        b_tmo_done;
        logic [31:0] b_cc_50, b_cc_end;

        rst = 1'b1; pc_a = '0; v_a = 1'b0; gp_a = '0;
        pc_b = '0; v_b = 1'b1; gp_b = '0;

        //           sel rst pc            v  gp            chk d  p  t  fnum          cc
        tbl[0]  = mk(0, 1, 32'h0,        1, 32'h0,        1, 0, 0, 0, 31'd0,        32'd0);
        tbl[1]  = mk(0, 1, 32'h44,       1, 32'h1,        1, 0, 0, 0, 31'd0,        32'd0);
        tbl[2]  = mk(0, 0, 32'h0,        1, 32'h0,        1, 0, 0, 0, 31'd0,        32'd1);
        tbl[3]  = mk(0, 0, 32'h44,       0, 32'h1,        1, 0, 0, 0, 31'd0,        32'd2);
        tbl[4]  = mk(0, 0, 32'h44,       0, 32'h1,        1, 0, 0, 0, 31'd0,        32'd3);
        tbl[5]  = mk(0, 0, 32'h44,       1, 32'h1,        1, 0, 0, 0, 31'd0,        32'd4);
        tbl[6]  = mk(0, 0, 32'h48,       1, 32'h1,        1, 0, 0, 0, 31'd0,        32'd5);
        tbl[7]  = mk(0, 0, 32'h44,       1, 32'h7,        1, 0, 0, 0, 31'd0,        32'd6);
        tbl[8]  = mk(0, 0, 32'h44,       0, 32'h7,        1, 0, 0, 0, 31'd0,        32'd7);
        tbl[9]  = mk(0, 0, 32'h44,       1, 32'h7,        1, 0, 0, 0, 31'd0,        32'd8);
        tbl[10] = mk(0, 0, 32'h44,       1, 32'h7,        1, 1, 0, 0, 31'd3,        32'd8);
        tbl[11] = mk(0, 0, 32'h44,       1, 32'h1,        1, 1, 0, 0, 31'd3,        32'd8);
        tbl[12] = mk(0, 0, 32'h0,        1, 32'h1,        1, 1, 0, 0, 31'd3,        32'd8);
        tbl[13] = mk(0, 1, 32'h0,        1, 32'h1,        1, 0, 0, 0, 31'd0,        32'd0);
        tbl[14] = mk(0, 0, 32'h0,        1, 32'h1,        1, 0, 0, 0, 31'd0,        32'd1);
        tbl[15] = mk(0, 0, 32'h44,       1, 32'h1,        1, 0, 0, 0, 31'd0,        32'd2);
        tbl[16] = mk(0, 0, 32'h44,       1, 32'h1,        1, 1, 1, 0, 31'd0,        32'd2);
        tbl[17] = mk(0, 1, 32'h44,       1, 32'h0,        1, 0, 0, 0, 31'd0,        32'd0);
        tbl[18] = mk(0, 0, 32'h44,       1, 32'h0,        1, 0, 0, 0, 31'd0,        32'd1);
        tbl[19] = mk(0, 0, 32'h44,       1, 32'h0,        1, 1, 0, 0, 31'd0,        32'd1);
        tbl[20] = mk(0, 1, 32'h0,        1, 32'h0,        1, 0, 0, 0, 31'd0,        32'd0);
        tbl[21] = mk(0, 0, 32'h44,       1, 32'hFFFF_FFFF, 1, 0, 0, 0, 31'd0,       32'd1);
        tbl[22] = mk(0, 0, 32'h44,       1, 32'hFFFF_FFFF, 1, 1, 0, 0, 31'h7FFF_FFFF, 32'd1);

        for (int i = 0; i < 23; i++) apply(tbl[i], "table", i);

`ifdef TEST_MONITOR_TIMEOUT_EN
        b_tmo_done = 1'b1; b_cc_50 = 32'd49; b_cc_end = 32'd49;
`else
        b_tmo_done = 1'b0; b_cc_50 = 32'd50; b_cc_end = 32'd202;
`endif

        // Long pass run on A while B idles toward its budget.
        pc_b = 32'h0; v_b = 1'b1; gp_b = 32'h0;
        apply(mk(0, 1, 32'h0, 1, 32'h0, 1, 0, 0, 0, 31'd0, 32'd0), "pass_rst", 0);
        for (int i = 1; i <= 100; i++) begin
            if (i == 49)
                apply(mk(1, 0, 32'h0, 1, 32'h0, 1, 0, 0, 0, 31'd0, 32'd49), "tmo_pre", i);
            else if (i == 50)
                apply(mk(1, 0, 32'h0, 1, 32'h0, 1, b_tmo_done, 0, b_tmo_done, 31'd0, b_cc_50),
                      "tmo_hit", i);
            else if (i == 100)
                apply(mk(0, 0, 32'h0, 1, 32'h0, 1, 0, 0, 0, 31'd0, 32'd100), "pass_idle", i);
            else
                apply(mk(0, 0, 32'h0, 1, 32'h0, 0, 0, 0, 0, 31'd0, 32'd0), "idle", i);
        end
        apply(mk(0, 0, 32'h44, 1, 32'h1, 1, 0, 0, 0, 31'd0, 32'd101), "pass_hold", 0);
        apply(mk(0, 0, 32'h44, 1, 32'h1, 1, 1, 1, 0, 31'd0, 32'd101), "pass_done", 0);
        for (int i = 1; i <= 100; i++) begin
            if (i == 99)
                apply(mk(0, 0, 32'h0, 1, 32'h5, 1, 1, 1, 0, 31'd0, 32'd101), "pass_sticky", i);
            else if (i == 100)
                apply(mk(1, 0, 32'h0, 1, 32'h0, 1, b_tmo_done, 0, b_tmo_done, 31'd0, b_cc_end),
                      "tmo_end", i);
            else
                apply(mk(0, 0, 32'h0, 1, 32'h0, 0, 0, 0, 0, 31'd0, 32'd0), "idle2", i);
        end

        // Completion on the same cycle as B's last budget cycle.
        apply(mk(1, 1, 32'h0, 1, 32'h0, 1, 0, 0, 0, 31'd0, 32'd0), "col_rst", 0);
        for (int i = 1; i <= 48; i++)
            apply(mk(1, 0, 32'h0, 1, 32'h0, 0, 0, 0, 0, 31'd0, 32'd0), "col_idle", i);
        pc_b = 32'h44; gp_b = 32'h1;
        apply(mk(1, 0, 32'h0, 1, 32'h0, 1, 0, 0, 0, 31'd0, 32'd49), "col_hold", 0);
        apply(mk(1, 0, 32'h0, 1, 32'h0, 1, 1, 1, 0, 31'd0, 32'd49), "col_done", 0);
        apply(mk(1, 1, 32'h0, 1, 32'h0, 1, 0, 0, 0, 31'd0, 32'd0), "pass_rst2", 0);
        apply(mk(1, 0, 32'h0, 1, 32'h0, 1, 0, 0, 0, 31'd0, 32'd1), "rerun_hold", 0);
        apply(mk(1, 0, 32'h0, 1, 32'h0, 1, 1, 1, 0, 31'd0, 32'd1), "rerun_done", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
